// File: rtl/rv32i_regfile_sb_if.sv
// rtl/rv32i_regfile_sb_if.sv - operand read, issue reservation and writeback bundle for the RV32I register file
interface rv32i_regfile_sb_if #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int NRD   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                iss_valid;
    logic [AW-1:0]       iss_rd;
    logic                iss_ready;
    logic                wb_enable;
    logic [AW-1:0]       wb_reg;
    logic [XLEN-1:0]     wb_data;
    logic [NREGS-1:0]    busy_vec;
    logic                wb_err;

    modport master (
        output rd_addr, iss_valid, iss_rd, wb_enable, wb_reg, wb_data,
        input  rd_data, rd_busy, iss_ready, busy_vec, wb_err
    );

    modport slave (
        input  rd_addr, iss_valid, iss_rd, wb_enable, wb_reg, wb_data,
        output rd_data, rd_busy, iss_ready, busy_vec, wb_err
    );
endinterface

// File: rtl/rv32i_regfile_sb.sv
// rtl/rv32i_regfile_sb.sv - RV32I integer register file with write bypass and per-register pending-write scoreboard
module rv32i_regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int CNTW   = 2,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              reset,
    rv32i_regfile_sb_if.slave bus
);
    localparam int              AW      = $clog2(NREGS);
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]     regs    [NREGS];
    logic [CNTW-1:0]     cnt     [NREGS];
    logic [CNTW-1:0]     cnt_nxt [NREGS];
    logic [NREGS-1:0]    acc_hit;
    logic [NREGS-1:0]    ret_hit;
    logic                wb_err_q;
    logic                err_set;
    logic                iss_acc;
    logic                wb_live;
    logic [AW-1:0]       a;
    logic [NRD*XLEN-1:0] rd_data_c;
    logic [NRD-1:0]      rd_busy_c;
    logic [NREGS-1:0]    busy_c;

    assign wb_live       = bus.wb_enable && (bus.wb_reg != '0);
    assign bus.iss_ready = (bus.iss_rd == '0) || (cnt[bus.iss_rd] != CNT_MAX);
    assign iss_acc       = bus.iss_valid && bus.iss_ready && (bus.iss_rd != '0);

    // A reservation and a retirement of the same register cancel out.
    always_comb begin
        err_set = 1'b0;
        acc_hit = '0;
        ret_hit = '0;
        for (int r = 0; r < NREGS; r++) begin
            acc_hit[r] = iss_acc && (bus.iss_rd == AW'(r));
            ret_hit[r] = wb_live && (bus.wb_reg == AW'(r));
        end
        for (int r = 0; r < NREGS; r++) begin
            cnt_nxt[r] = cnt[r];
            if (acc_hit[r] && !ret_hit[r]) begin
                cnt_nxt[r] = cnt[r] + CNTW'(1);
            end else if (!acc_hit[r] && ret_hit[r]) begin
                if (cnt[r] != '0) begin
                    cnt_nxt[r] = cnt[r] - CNTW'(1);
                end else begin
                    err_set = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
                cnt[r]  <= '0;
            end
            wb_err_q <= 1'b0;
        end else begin
            if (wb_live) begin
                regs[bus.wb_reg] <= bus.wb_data;
            end
            for (int r = 0; r < NREGS; r++) begin
                cnt[r] <= cnt_nxt[r];
            end
            if (err_set) begin
                wb_err_q <= 1'b1;
            end
        end
    end

    // Forwarding is suppressed while reset is held so reads show the cleared array.
    always_comb begin
        rd_data_c = '0;
        rd_busy_c = '0;
        a         = '0;
        for (int i = 0; i < NRD; i++) begin
            a = bus.rd_addr[i*AW +: AW];
            if (a != '0) begin
                if ((BYPASS != 0) && reset && bus.wb_enable && (bus.wb_reg == a)) begin
                    rd_data_c[i*XLEN +: XLEN] = bus.wb_data;
                end else begin
                    rd_data_c[i*XLEN +: XLEN] = regs[a];
                end
                rd_busy_c[i] = (cnt[a] != '0) &&
                               !(bus.wb_enable && (bus.wb_reg == a) && (cnt[a] == CNTW'(1)));
            end
        end
    end

    always_comb begin
        busy_c = '0;
        for (int r = 1; r < NREGS; r++) begin
            busy_c[r] = (cnt[r] != '0);
        end
    end

    assign bus.rd_data  = rd_data_c;
    assign bus.rd_busy  = rd_busy_c;
    assign bus.busy_vec = busy_c;
    assign bus.wb_err   = wb_err_q;
endmodule
